// File: rtl/reg_bank_param.sv
// Instruction-driven register bank: 2^SEL_WIDTH registers of DATA_WIDTH bits with
// load/inc/dec/move, a selectable read port, a sequential bank clear and a sticky error state.
module reg_bank_param #(
  parameter  int DATA_WIDTH = 8,
  parameter  int SEL_WIDTH  = 3,
  localparam int REG_COUNT  = 2 ** SEL_WIDTH,
  localparam int INST_WIDTH = 4 + SEL_WIDTH + DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [INST_WIDTH-1:0] inst,
  input  logic                  inst_en,
  output logic                  ready,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] out
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_READY = 2'd1,
    ST_CLEAR = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
  logic [SEL_WIDTH-1:0]  osel_q, osel_d;
  logic [SEL_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  error_q, error_d;

  logic [3:0]            code_s;
  logic [SEL_WIDTH-1:0]  sel_s;
  logic [DATA_WIDTH-1:0] imm_s;
  logic [SEL_WIDTH-1:0]  src_s;

  assign code_s = inst[INST_WIDTH-1 -: 4];
  assign sel_s  = inst[DATA_WIDTH +: SEL_WIDTH];
  assign imm_s  = inst[DATA_WIDTH-1:0];
  assign src_s  = imm_s[SEL_WIDTH-1:0];

  // Next-state, register-file and flag computation
  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    osel_d  = osel_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RESET: begin
        state_d = ST_READY;
      end
      ST_READY: begin
        if (inst_en) begin
          case (code_s)
            4'd0: state_d = ST_READY;
            4'd1: osel_d = sel_s;
            4'd2: regs_d[sel_s] = imm_s;
            4'd3: regs_d[sel_s] = regs_q[sel_s] + DATA_WIDTH'(1);
            4'd4: regs_d[sel_s] = regs_q[sel_s] - DATA_WIDTH'(1);
            4'd5: begin
              state_d = ST_CLEAR;
              cnt_d   = '0;
            end
            4'd6: regs_d[sel_s] = regs_q[src_s];
            default: begin
              state_d = ST_ERROR;
              osel_d  = '0;
              for (int i = 0; i < REG_COUNT; i++) regs_d[i] = '0;
            end
          endcase
        end else begin
          state_d = ST_READY;
        end
      end
      ST_CLEAR: begin
        // One register per cycle; the last one hands control back to Ready
        regs_d[cnt_q] = '0;
        cnt_d         = cnt_q + SEL_WIDTH'(1);
        if (cnt_q == SEL_WIDTH'(REG_COUNT - 1)) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
        osel_d  = '0;
        for (int i = 0; i < REG_COUNT; i++) regs_d[i] = '0;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
    ready_d = (state_d == ST_READY);
    error_d = (state_d == ST_ERROR);
  end

  // State, register file and status flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RESET;
      osel_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      osel_q  <= osel_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      error_q <= error_d;
      regs_q  <= regs_d;
    end
  end

  assign ready = ready_q;
  assign error = error_q;
  assign out   = regs_q[osel_q];

endmodule
